i2s_sample_bridge: RTL and testbench
====================================

# i2s_sample_bridge

Sits between `i2s_transceiver` and the equalizer DSP chain, in the `mclk` domain.
- Receive side: at each frame boundary, captures the transceiver's parallel left/right receive words and serialises them into a valid/ready sample stream (left, then right).
- Transmit side: collects processed left/right samples from the DSP return stream and commits them as an atomic pair onto the transceiver's transmit inputs, aligned to word select so the channels never mix frames.

## Interface
Parameters:
- `d_width`, 24: audio sample width; must match the transceiver.

Ports:
- `mclk`  in  1  master clock, the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ws`  in  1  word select from the transceiver (same clock domain, no synchroniser).
- `l_data_rx`, `r_data_rx`  in  `d_width`  received words from the transceiver.
- `l_data_tx`, `r_data_tx`  out  `d_width`  words to transmit, to the transceiver.
- `m_data`  out  `d_width`  outbound sample to the DSP.
- `m_chan`  out  1  outbound channel tag: 0 = left, 1 = right.
- `m_valid`  out  1  outbound sample valid.
- `m_ready`  in  1  DSP accepts the outbound sample.
- `s_data`  in  `d_width`  processed sample from the DSP.
- `s_chan`  in  1  return channel tag.
- `s_valid`  in  1  return sample valid.
- `s_ready`  out  1  bridge accepts the return sample.
- `rx_overrun`  out  1  sticky flag: a captured frame was dropped.
- `tx_underrun`  out  1  sticky flag: a commit point arrived with no complete pair.

## Operation
- **Edge detect:** `ws_q` is a register of `ws` with reset value 1.
  - fall = `ws_q & ~ws` (a left word starts; both rx words are complete).
  - rise = `~ws_q & ws`.
- **Receive FSM**, states IDLE, SEND_L, SEND_R:
  - IDLE: on fall, latch `l_data_rx` into `l_cap` and `r_data_rx` into `r_cap`, then go to SEND_L.
  - SEND_L: drive `m_data`=`l_cap`, `m_chan`=0, `m_valid`=1. On `m_ready`, go to SEND_R.
  - SEND_R: drive `m_data`=`r_cap`, `m_chan`=1, `m_valid`=1. On `m_ready`, go to IDLE.
  - A fall in any state other than IDLE is an overrun: the frame is dropped, `rx_overrun` is set, and the captures and state are unchanged.
- **AXI-style rule:** once `m_valid` rises, `m_data` and `m_chan` are held stable until the handshake completes.
- **Return collector:**
  - `s_ready` = `~pair_pending`.
  - A handshake with `s_chan`=0 writes `l_hold` and sets `l_got`; with `s_chan`=1 it writes `r_hold` and sets `r_got`.
  - A repeat of a channel overwrites the held value (last wins).
  - When `l_got & r_got`, `pair_pending` is set and both got flags clear.
- **Commit:** the cycle after rise is detected:
  - If `pair_pending`: `l_data_tx` ← `l_hold`, `r_data_tx` ← `r_hold`, and `pair_pending` clears.
  - Otherwise: the outputs hold their previous values and `tx_underrun` is set.
  - Reason for committing after rise: the transceiver loads the new left word at the next fall and the new right word at the following rise, so the pair stays consistent.
- **Reset values:** all outputs 0 except `s_ready`=1; FSM in IDLE; `ws_q`=1; all flags 0. Sticky flags clear only on reset.
- **Reset mid-operation:**
  - Any in-flight stream beat is abandoned.
  - `m_valid` drops asynchronously.
  - A partial return pair is discarded.

## Timing
- **Rx latency:** ws falls at edge N; fall is detected at edge N+1, where the captures load; `m_valid`=1 with left from edge N+1 onward.
- **Stream throughput:** with `m_ready` held high, left and right are each accepted in one cycle, so the FSM is back in IDLE 2 cycles after `m_valid` rises.
- **DSP budget:** a frame period is `2*sclk_ws_ratio*mclk_sclk_ratio` mclk cycles, 512 with transceiver defaults. The DSP must return both samples before the next rise.
- **Return path:**
  - `s_ready` drops the cycle after the completing handshake.
  - `s_ready` returns to 1 the cycle after commit.
- **Simultaneous events:**
  - Return handshake in the commit cycle: it is refused, because `s_ready`=0 while pending.
  - Fall while returning to IDLE on the same edge (SEND_R with `m_ready`): counts as an overrun, so the DSP must drain within one frame.

## Structure
- **Shared package** `eq_audio_pkg` holds:
  - `CH_LEFT` = 0, `CH_RIGHT` = 1.
  - The receive-FSM state encoding.
  - The default `d_width`.
- **Sub-module** `i2s_return_collector`: owns the hold registers, got flags, `pair_pending`, `s_ready`, and commit logic. Its inputs are the return stream and a commit strobe.
- The top level holds the edge detect, the receive FSM and the sticky flags.

## Test plan
- **Single frame:** `l_data_rx`=0x123456, `r_data_rx`=0xABCDEF, one ws fall, `m_ready`=1 → beats (0x123456, chan 0) then (0xABCDEF, chan 1) on consecutive cycles, starting one cycle after the fall is sampled.
- **Backpressure:** `m_ready` low for 10 cycles → left beat held stable with `m_valid`=1 throughout; right follows after `m_ready` rises.
- **Loopback:** return right 0x000002 then left 0x000001, then ws rise → `l_data_tx`=0x000001 and `r_data_tx`=0x000002 the cycle after rise; `s_ready` back to 1 at the same point.
- **Overrun/underrun:** `m_ready`=0 across two ws falls → `rx_overrun`=1 and the first frame is still delivered intact. A ws rise with no return → `tx_underrun`=1 and tx outputs unchanged.
- **Reset mid-beat:** assert `reset_n`=0 while in SEND_R → `m_valid`=0 immediately, tx outputs 0, `s_ready`=1. The next frame after release streams normally.

Source files
------------

// File: rtl/eq_audio_pkg.sv
// Shared definitions for the equalizer audio path: channel tags, default
// sample width and the receive-side stream FSM encoding.
package eq_audio_pkg;

  localparam int unsigned D_WIDTH_DEF = 24;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_SEND_L = 2'd1,
    RX_SEND_R = 2'd2
  } rx_state_t;

endpackage

// File: rtl/i2s_return_collector.sv
// Gathers one left and one right processed sample from the DSP return stream
// and transfers them together onto the transmit words on a commit strobe.
module i2s_return_collector
  import eq_audio_pkg::*;
#(
  parameter int unsigned d_width = D_WIDTH_DEF
) (
  input  logic               mclk,
  input  logic               reset_n,
  input  logic [d_width-1:0] s_data,
  input  logic               s_chan,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               commit,
  output logic [d_width-1:0] l_data_tx,
  output logic [d_width-1:0] r_data_tx,
  output logic               commit_miss
);

  logic [d_width-1:0] l_hold_r, r_hold_r, l_hold_s, r_hold_s;
  logic [d_width-1:0] l_tx_r, r_tx_r, l_tx_s, r_tx_s;
  logic               l_got_r, r_got_r, l_got_s, r_got_s;
  logic               pending_r, pending_s;
  logic               s_ready_r, s_ready_s;
  logic               hs_s;

  assign s_ready     = s_ready_r;
  assign l_data_tx   = l_tx_r;
  assign r_data_tx   = r_tx_r;
  assign commit_miss = commit & ~pending_r;
  assign hs_s        = s_valid & s_ready_r;

  // Next-state for hold registers, got flags, pending pair and tx words
  always_comb begin
    l_hold_s  = l_hold_r;
    r_hold_s  = r_hold_r;
    l_got_s   = l_got_r;
    r_got_s   = r_got_r;
    pending_s = pending_r;
    s_ready_s = s_ready_r;
    l_tx_s    = l_tx_r;
    r_tx_s    = r_tx_r;
    if (commit && pending_r) begin
      l_tx_s    = l_hold_r;
      r_tx_s    = r_hold_r;
      pending_s = 1'b0;
      s_ready_s = 1'b1;
    end else begin
      l_tx_s = l_tx_r;
    end
    // hs_s can only fire while nothing is pending, so it never races a commit
    if (hs_s) begin
      if (s_chan == CH_LEFT) begin
        l_hold_s = s_data;
        l_got_s  = 1'b1;
      end else begin
        r_hold_s = s_data;
        r_got_s  = 1'b1;
      end
      if (l_got_s && r_got_s) begin
        pending_s = 1'b1;
        s_ready_s = 1'b0;
        l_got_s   = 1'b0;
        r_got_s   = 1'b0;
      end else begin
        pending_s = pending_r;
      end
    end else begin
      l_hold_s = l_hold_r;
    end
  end

  // Collector state registers
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      l_hold_r  <= {d_width{1'b0}};
      r_hold_r  <= {d_width{1'b0}};
      l_got_r   <= 1'b0;
      r_got_r   <= 1'b0;
      pending_r <= 1'b0;
      s_ready_r <= 1'b1;
      l_tx_r    <= {d_width{1'b0}};
      r_tx_r    <= {d_width{1'b0}};
    end else begin
      l_hold_r  <= l_hold_s;
      r_hold_r  <= r_hold_s;
      l_got_r   <= l_got_s;
      r_got_r   <= r_got_s;
      pending_r <= pending_s;
      s_ready_r <= s_ready_s;
      l_tx_r    <= l_tx_s;
      r_tx_r    <= r_tx_s;
    end
  end

endmodule

// File: rtl/i2s_sample_bridge.sv
// Bridges i2s_transceiver parallel words to a valid/ready DSP sample stream
// and commits returned sample pairs aligned to word select.
module i2s_sample_bridge
  import eq_audio_pkg::*;
#(
  parameter int unsigned d_width = D_WIDTH_DEF
) (
  input  logic               mclk,
  input  logic               reset_n,
  input  logic               ws,
  input  logic [d_width-1:0] l_data_rx,
  input  logic [d_width-1:0] r_data_rx,
  output logic [d_width-1:0] l_data_tx,
  output logic [d_width-1:0] r_data_tx,
  output logic [d_width-1:0] m_data,
  output logic               m_chan,
  output logic               m_valid,
  input  logic               m_ready,
  input  logic [d_width-1:0] s_data,
  input  logic               s_chan,
  input  logic               s_valid,
  output logic               s_ready,
  output logic               rx_overrun,
  output logic               tx_underrun
);

  rx_state_t          state_r, state_s;
  logic               ws_q_r, fall_s, rise_s, commit_r, commit_miss_s;
  logic [d_width-1:0] l_cap_r, r_cap_r, l_cap_s, r_cap_s;
  logic [d_width-1:0] m_data_r, m_data_s;
  logic               m_chan_r, m_chan_s, m_valid_r, m_valid_s;
  logic               overrun_s, rx_overrun_r, tx_underrun_r;

  assign fall_s      = ws_q_r & ~ws;
  assign rise_s      = ~ws_q_r & ws;
  assign m_data      = m_data_r;
  assign m_chan      = m_chan_r;
  assign m_valid     = m_valid_r;
  assign rx_overrun  = rx_overrun_r;
  assign tx_underrun = tx_underrun_r;

  // Receive FSM next state, captures and next stream outputs
  always_comb begin
    state_s   = state_r;
    l_cap_s   = l_cap_r;
    r_cap_s   = r_cap_r;
    overrun_s = 1'b0;
    m_data_s  = m_data_r;
    m_chan_s  = m_chan_r;
    m_valid_s = 1'b0;
    case (state_r)
      RX_IDLE: begin
        if (fall_s) begin
          l_cap_s = l_data_rx;
          r_cap_s = r_data_rx;
          state_s = RX_SEND_L;
        end else begin
          state_s = RX_IDLE;
        end
      end
      RX_SEND_L: begin
        if (m_ready) state_s = RX_SEND_R;
        else         state_s = RX_SEND_L;
      end
      RX_SEND_R: begin
        if (m_ready) state_s = RX_IDLE;
        else         state_s = RX_SEND_R;
      end
      default: state_s = RX_IDLE;
    endcase
    // A fall that the FSM cannot take (even while draining the right beat) drops the frame
    if (fall_s && (state_r != RX_IDLE)) overrun_s = 1'b1;
    else                                overrun_s = 1'b0;
    case (state_s)
      RX_SEND_L: begin
        m_data_s  = l_cap_s;
        m_chan_s  = CH_LEFT;
        m_valid_s = 1'b1;
      end
      RX_SEND_R: begin
        m_data_s  = r_cap_s;
        m_chan_s  = CH_RIGHT;
        m_valid_s = 1'b1;
      end
      default: begin
        m_valid_s = 1'b0;
      end
    endcase
  end

  // Edge detect, FSM state, captures, stream outputs and sticky flags
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      ws_q_r        <= 1'b1;
      commit_r      <= 1'b0;
      state_r       <= RX_IDLE;
      l_cap_r       <= {d_width{1'b0}};
      r_cap_r       <= {d_width{1'b0}};
      m_data_r      <= {d_width{1'b0}};
      m_chan_r      <= 1'b0;
      m_valid_r     <= 1'b0;
      rx_overrun_r  <= 1'b0;
      tx_underrun_r <= 1'b0;
    end else begin
      ws_q_r        <= ws;
      commit_r      <= rise_s;
      state_r       <= state_s;
      l_cap_r       <= l_cap_s;
      r_cap_r       <= r_cap_s;
      m_data_r      <= m_data_s;
      m_chan_r      <= m_chan_s;
      m_valid_r     <= m_valid_s;
      rx_overrun_r  <= rx_overrun_r | overrun_s;
      tx_underrun_r <= tx_underrun_r | commit_miss_s;
    end
  end

  i2s_return_collector #(.d_width(d_width)) u_collector (
    .mclk        (mclk),
    .reset_n     (reset_n),
    .s_data      (s_data),
    .s_chan      (s_chan),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .commit      (commit_r),
    .l_data_tx   (l_data_tx),
    .r_data_tx   (r_data_tx),
    .commit_miss (commit_miss_s)
  );

endmodule

// File: tb/tb_i2s_sample_bridge.sv
// Directed self-checking bench for i2s_sample_bridge.
module tb_i2s_sample_bridge;

  localparam int unsigned DW = 24;

  logic          mclk = 1'b0;
  logic          reset_n;
  logic          ws;
  logic [DW-1:0] l_data_rx, r_data_rx, l_data_tx, r_data_tx;
  logic [DW-1:0] m_data, s_data;
  logic          m_chan, m_valid, m_ready;
  logic          s_chan, s_valid, s_ready;
  logic          rx_overrun, tx_underrun;

  int checks = 0;
  int errors = 0;

  always #5 mclk = ~mclk;

  i2s_sample_bridge #(.d_width(DW)) dut (
    .mclk        (mclk),
    .reset_n     (reset_n),
    .ws          (ws),
    .l_data_rx   (l_data_rx),
    .r_data_rx   (r_data_rx),
    .l_data_tx   (l_data_tx),
    .r_data_tx   (r_data_tx),
    .m_data      (m_data),
    .m_chan      (m_chan),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .s_data      (s_data),
    .s_chan      (s_chan),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .rx_overrun  (rx_overrun),
    .tx_underrun (tx_underrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic check_beat(input string tag, input logic v, input logic [DW-1:0] d, input logic c);
    check_eq({tag, "_valid"}, {31'd0, m_valid}, {31'd0, v});
    check_eq({tag, "_data"}, {8'd0, m_data}, {8'd0, d});
    check_eq({tag, "_chan"}, {31'd0, m_chan}, {31'd0, c});
  endtask

  task automatic ret(input logic ch, input logic [DW-1:0] d);
    s_valid = 1'b1;
    s_chan  = ch;
    s_data  = d;
    tick();
    s_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; ws = 1'b1; m_ready = 1'b0;
    l_data_rx = 24'h0; r_data_rx = 24'h0;
    s_data = 24'h0; s_chan = 1'b0; s_valid = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check_eq("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check_eq("rst_m_data", {8'd0, m_data}, 32'd0);
    check_eq("rst_s_ready", {31'd0, s_ready}, 32'd1);
    check_eq("rst_l_tx", {8'd0, l_data_tx}, 32'd0);
    check_eq("rst_r_tx", {8'd0, r_data_tx}, 32'd0);
    check_eq("rst_ovr", {31'd0, rx_overrun}, 32'd0);
    check_eq("rst_udr", {31'd0, tx_underrun}, 32'd0);

    // single frame, m_ready high
    l_data_rx = 24'h123456; r_data_rx = 24'hABCDEF; m_ready = 1'b1;
    ws = 1'b0;
    tick();
    check_beat("sf_l", 1'b1, 24'h123456, 1'b0);
    tick();
    check_beat("sf_r", 1'b1, 24'hABCDEF, 1'b1);
    tick();
    check_eq("sf_idle", {31'd0, m_valid}, 32'd0);

    // loopback: right then left, refused beat while pending, commit after rise
    ret(1'b1, 24'h000002);
    check_eq("lb_ready_half", {31'd0, s_ready}, 32'd1);
    ret(1'b0, 24'h000001);
    check_eq("lb_ready_drop", {31'd0, s_ready}, 32'd0);
    ret(1'b0, 24'h000055);
    check_eq("lb_still_pend", {31'd0, s_ready}, 32'd0);
    ws = 1'b1;
    tick();
    check_eq("lb_l_tx_pre", {8'd0, l_data_tx}, 32'd0);
    tick();
    check_eq("lb_l_tx", {8'd0, l_data_tx}, 32'h000001);
    check_eq("lb_r_tx", {8'd0, r_data_tx}, 32'h000002);
    check_eq("lb_ready_back", {31'd0, s_ready}, 32'd1);
    check_eq("lb_udr", {31'd0, tx_underrun}, 32'd0);

    // backpressure: left beat held for 10 cycles
    l_data_rx = 24'hA5A5A5; r_data_rx = 24'h5A5A5A; m_ready = 1'b0;
    ws = 1'b0;
    tick();
    l_data_rx = 24'h000000; r_data_rx = 24'h000000;
    for (int i = 0; i < 10; i++) begin
      check_beat("bp_hold", 1'b1, 24'hA5A5A5, 1'b0);
      tick();
    end
    m_ready = 1'b1;
    tick();
    check_beat("bp_r", 1'b1, 24'h5A5A5A, 1'b1);
    tick();
    check_eq("bp_idle", {31'd0, m_valid}, 32'd0);
    check_eq("bp_ovr", {31'd0, rx_overrun}, 32'd0);

    // underrun: rise with no returned pair
    ws = 1'b1;
    tick();
    tick();
    check_eq("ur_flag", {31'd0, tx_underrun}, 32'd1);
    check_eq("ur_l_tx", {8'd0, l_data_tx}, 32'h000001);
    check_eq("ur_r_tx", {8'd0, r_data_tx}, 32'h000002);

    // overrun: second fall while first frame is stalled
    m_ready = 1'b0;
    l_data_rx = 24'h111111; r_data_rx = 24'h222222;
    ws = 1'b0;
    tick();
    check_beat("ov_l", 1'b1, 24'h111111, 1'b0);
    l_data_rx = 24'h333333; r_data_rx = 24'h444444;
    ws = 1'b1;
    tick();
    ws = 1'b0;
    tick();
    check_eq("ov_flag", {31'd0, rx_overrun}, 32'd1);
    check_beat("ov_l_kept", 1'b1, 24'h111111, 1'b0);
    m_ready = 1'b1;
    tick();
    check_beat("ov_r", 1'b1, 24'h222222, 1'b1);
    tick();
    check_eq("ov_idle", {31'd0, m_valid}, 32'd0);

    // reset while in SEND_R with a partial return pair held
    ws = 1'b1;
    tick();
    l_data_rx = 24'h0F0F0F; r_data_rx = 24'hF0F0F0; m_ready = 1'b0;
    ws = 1'b0;
    tick();
    m_ready = 1'b1;
    s_valid = 1'b1; s_chan = 1'b0; s_data = 24'h000777;
    tick();
    s_valid = 1'b0; m_ready = 1'b0;
    check_beat("rm_r", 1'b1, 24'hF0F0F0, 1'b1);
    ws = 1'b1;
    reset_n = 1'b0;
    #1;
    check_eq("rm_valid_async", {31'd0, m_valid}, 32'd0);
    check_eq("rm_l_tx", {8'd0, l_data_tx}, 32'd0);
    check_eq("rm_r_tx", {8'd0, r_data_tx}, 32'd0);
    check_eq("rm_s_ready", {31'd0, s_ready}, 32'd1);
    check_eq("rm_ovr_clr", {31'd0, rx_overrun}, 32'd0);
    #2;
    reset_n = 1'b1;
    tick();
    l_data_rx = 24'hCAFE01; r_data_rx = 24'hCAFE02; m_ready = 1'b1;
    ws = 1'b0;
    tick();
    check_beat("pr_l", 1'b1, 24'hCAFE01, 1'b0);
    tick();
    check_beat("pr_r", 1'b1, 24'hCAFE02, 1'b1);
    tick();
    // left half was discarded by reset, so a right alone must not complete a pair
    ret(1'b1, 24'h000888);
    check_eq("pr_partial_drop", {31'd0, s_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
